instr_encoder: RTL

Streaming RV32I instruction encoder. Accepts decoded instruction fields plus a full 32-bit immediate, range-checks the immediate, and scatters it into the format-specific bit positions. This is the exact inverse of the immediate-extension step in the core datapath. Emits packed instruction words with sequential instruction-memory byte addresses, so the packed words can be written into imem by the program loader. Sits between the host/UART command path and the instruction memory write port.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/imm_scatter.sv | 61 ++++++
 rtl/instr_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// imm_fmt_t codes match the ImmSrc encoding used by the controller and the immediate extender.
package encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;

    // True when every bit of the vector has the same value, i.e. the upper
    // bits of a two's-complement number are pure sign extension.
    function automatic logic all_equal(input logic [31:0] bits, input logic [31:0] mask);
        return ((bits & mask) == mask) || ((bits & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational packer: range-checks the immediate and scatters it into the
// format-specific bit positions, the inverse of the datapath's immediate extender.
module imm_scatter
    import encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic        i_rtype,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_reject
);

    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    assign w_fits12 = all_equal(i_imm, 32'hFFFF_F800);
    assign w_fits13 = all_equal(i_imm, 32'hFFFF_F000);
    assign w_fits21 = all_equal(i_imm, 32'hFFF0_0000);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_instr  = 32'h0;
        o_reject = 1'b0;
        if (i_rtype) begin
            o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        end else begin
            case (i_fmt)
                FMT_I: begin
                    o_instr  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                    o_reject = !w_fits12;
                end
                FMT_S: begin
                    o_instr  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                    o_reject = !w_fits12;
                end
                FMT_B: begin
                    o_instr  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                i_imm[4:1], i_imm[11], i_opcode};
                    o_reject = !w_fits13 || i_imm[0];
                end
                FMT_J: begin
                    o_instr  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                    o_reject = !w_fits21 || i_imm[0];
                end
                FMT_U: begin
                    o_instr  = {i_imm[31:12], i_rd, i_opcode};
                    o_reject = |i_imm[11:0];
                end
                default: o_reject = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one output register stage with valid/ready handshake,
// sequential imem byte addresses, and reject/emit counters.
module instr_encoder
    import encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic        in_rtype,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] word_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic [31:0]      r_out_addr;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic [7:0]       r_err_count;
    logic [15:0]      r_word_count;

    logic [31:0] w_instr;
    logic        w_reject;
    logic        w_accept;
    logic        w_load;
    logic        w_drop;
    logic        w_drain;
    logic [31:0] w_addr;

    imm_scatter u_scatter (
        .i_fmt    (in_fmt),
        .i_rtype  (in_rtype),
        .i_opcode (in_opcode),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_instr  (w_instr),
        .o_reject (w_reject)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && !w_reject;
    assign w_drop   = w_accept && w_reject;
    assign w_drain  = r_out_valid && out_ready;
    // Power-of-two DEPTH lets the index wrap by natural overflow.
    assign w_addr   = BASE_ADDR + (32'(r_idx) << 2);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'h0;
            r_out_addr   <= BASE_ADDR;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_err_count  <= 8'h0;
            r_word_count <= 16'h0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= w_addr;
                r_idx       <= r_idx + 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop) begin
                r_err <= 1'b1;
                if (r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
            end

            if (w_drain)
                r_word_count <= r_word_count + 16'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_addr   = r_out_addr;
    assign err        = r_err;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule
